// File: rtl/pa_ifu_sram_ctrl_256x41.sv
// Initiator-side controller for the 256x41 IFU SRAM: full-array clear after reset or on
// request, otherwise one write or one read per cycle with one-cycle read return.
module pa_ifu_sram_ctrl_256x41 #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 41,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_busy,
  output logic                  inv_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {START, INIT, IDLE, INV} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_next;
  logic                    sweep_last;

  // State, sweep counter, read-return valid and clear-complete pulse
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= START;
      cnt      <= '0;
      rd_vld   <= 1'b0;
      inv_done <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_next;
      rd_vld   <= rd_gnt;
      inv_done <= sweep_last;
    end
  end

  // Next state, grants and SRAM controls; the SRAM is idle unless a case drives it
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    sweep_last = 1'b0;
    inv_busy   = 1'b1;
    wr_gnt     = 1'b0;
    rd_gnt     = 1'b0;
    sram_cen   = 1'b1;
    sram_gwen  = 1'b1;
    sram_wen   = '1;
    sram_a     = '0;
    sram_d     = '0;
    case (state)
      START: begin
        next_state = INIT;
      end
      INIT, INV: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt;
        sram_d    = INIT_VAL;
        cnt_next  = cnt + CNT_ONE;
        if (cnt == '1) begin
          sweep_last = 1'b1;
          next_state = IDLE;
        end
      end
      IDLE: begin
        inv_busy = 1'b0;
        if (inv_req) begin
          next_state = INV;
        end else if (wr_req) begin
          wr_gnt    = 1'b1;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = ~wr_mask;
          sram_a    = wr_addr;
          sram_d    = wr_data;
        end else if (rd_req) begin
          rd_gnt   = 1'b1;
          sram_cen = 1'b0;
          sram_a   = rd_addr;
        end
      end
      default: begin
        next_state = START;
      end
    endcase
  end

  // Read data is forced to zero outside the valid cycle
  assign rd_data = rd_vld ? sram_q : '0;

endmodule

// File: tb/tb_pa_ifu_sram_ctrl_256x41.sv
// Directed self-checking bench for pa_ifu_sram_ctrl_256x41 with a behavioural SRAM macro.
module tb_pa_ifu_sram_ctrl_256x41;

  logic        clk;
  logic        rst_n;
  logic        inv_req;
  logic        inv_busy;
  logic        inv_done;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [40:0] wr_data;
  logic [40:0] wr_mask;
  logic        wr_gnt;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_gnt;
  logic        rd_vld;
  logic [40:0] rd_data;
  logic [7:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [40:0] sram_wen;
  logic [40:0] sram_d;
  logic [40:0] sram_q;

  int testsRun = 0;
  int failCount = 0;

  logic [40:0] mem [256];

  pa_ifu_sram_ctrl_256x41 dut (
    .forever_cpuclk(clk),
    .cpurst_b(rst_n),
    .inv_req(inv_req),
    .inv_busy(inv_busy),
    .inv_done(inv_done),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_mask(wr_mask),
    .wr_gnt(wr_gnt),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_gnt(rd_gnt),
    .rd_vld(rd_vld),
    .rd_data(rd_data),
    .sram_a(sram_a),
    .sram_cen(sram_cen),
    .sram_gwen(sram_gwen),
    .sram_wen(sram_wen),
    .sram_d(sram_d),
    .sram_q(sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port SRAM model: active-low controls, per-bit write enable, one-cycle read
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= mem[sram_a];
    end
  end

  function automatic logic [40:0] patt(input int i);
    return 41'h155_0000_0000 | (41'(i) * 41'h0_0013_579B);
  endfunction

  task automatic applyStimulus(input logic wr, input logic [7:0] wa, input logic [40:0] wd,
                               input logic [40:0] wm, input logic rd, input logic [7:0] ra,
                               input logic inv);
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
    wr_mask = wm;
    rd_req  = rd;
    rd_addr = ra;
    inv_req = inv;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [40:0] observed, input logic [40:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, 1'b0);
    #2;
    checkOutput("rst_busy", 41'(inv_busy), 41'd1);
    checkOutput("rst_done", 41'(inv_done), 41'd0);
    checkOutput("rst_gnt", 41'({wr_gnt, rd_gnt}), 41'd0);
    checkOutput("rst_vld", 41'(rd_vld), 41'd0);
    checkOutput("rst_rdata", rd_data, 41'd0);
    checkOutput("rst_cen_gwen", 41'({sram_cen, sram_gwen}), 41'd3);
    checkOutput("rst_wen", sram_wen, {41{1'b1}});
    checkOutput("rst_a", 41'(sram_a), 41'd0);
    checkOutput("rst_d", sram_d, 41'd0);

    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Initial clear: 256 writes of INIT_VAL to 0..255
    for (int k = 0; k < 256; k++) begin
      nextCycle();
      checkOutput("init_a", 41'(sram_a), 41'(k));
      checkOutput("init_ctl", 41'({sram_cen, sram_gwen, inv_busy}), 41'b001);
      if (k == 0) begin
        checkOutput("init_wen", sram_wen, 41'd0);
        checkOutput("init_d", sram_d, 41'd0);
      end
      if (k == 255) checkOutput("init_done_early", 41'(inv_done), 41'd0);
    end
    nextCycle();
    checkOutput("init_done", 41'(inv_done), 41'd1);
    checkOutput("init_busy_low", 41'(inv_busy), 41'd0);
    checkOutput("idle_cen", 41'(sram_cen), 41'd1);

    // Write 0x3A in the first IDLE cycle, read it back next cycle
    applyStimulus(1'b1, 8'h3A, 41'h1_2345_6789A, {41{1'b1}}, 1'b0, 8'h00, 1'b0);
    checkOutput("wr_gnt", 41'(wr_gnt), 41'd1);
    checkOutput("wr_ctl", 41'({sram_cen, sram_gwen}), 41'd0);
    checkOutput("wr_wen", sram_wen, 41'd0);
    checkOutput("wr_a", 41'(sram_a), 41'h3A);
    checkOutput("wr_d", sram_d, 41'h1_2345_6789A);
    nextCycle();
    checkOutput("done_pulse_end", 41'(inv_done), 41'd0);
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'h3A, 1'b0);
    checkOutput("rd_gnt", 41'({rd_gnt, wr_gnt}), 41'b10);
    checkOutput("rd_ctl", 41'({sram_cen, sram_gwen}), 41'b01);
    checkOutput("rd_wen", sram_wen, {41{1'b1}});
    checkOutput("rd_a", 41'(sram_a), 41'h3A);
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, 1'b0);
    checkOutput("rd_vld", 41'(rd_vld), 41'd1);
    checkOutput("rd_data_3a", rd_data, 41'h1_2345_6789A);
    checkOutput("idle_cen2", 41'(sram_cen), 41'd1);
    nextCycle();
    checkOutput("rd_vld_drop", 41'(rd_vld), 41'd0);
    checkOutput("rd_data_zero", rd_data, 41'd0);

    // Masked write to a cleared entry
    applyStimulus(1'b1, 8'h10, 41'h1FF_FFFF_FFFF, 41'h000_0000_00FF, 1'b0, 8'h00, 1'b0);
    checkOutput("mask_wen", sram_wen, ~41'h000_0000_00FF);
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'h10, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, 1'b0);
    checkOutput("mask_rdata", rd_data, 41'h000_0000_00FF);
    nextCycle();

    // Zero mask: still granted, nothing changes
    applyStimulus(1'b1, 8'h11, 41'h1FF_FFFF_FFFF, 41'd0, 1'b0, 8'h00, 1'b0);
    checkOutput("mask0_gnt", 41'(wr_gnt), 41'd1);
    checkOutput("mask0_wen", sram_wen, {41{1'b1}});
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'h11, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, 1'b0);
    checkOutput("mask0_rdata", rd_data, 41'd0);
    nextCycle();

    // Fill 0..7, then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(i), patt(i), {41{1'b1}}, 1'b0, 8'h00, 1'b0);
      nextCycle();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'(i), 1'b0);
      checkOutput("b2b_gnt", 41'(rd_gnt), 41'd1);
      if (i > 0) begin
        checkOutput("b2b_vld", 41'(rd_vld), 41'd1);
        checkOutput("b2b_data", rd_data, patt(i - 1));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, 1'b0);
    checkOutput("b2b_vld_last", 41'(rd_vld), 41'd1);
    checkOutput("b2b_data_last", rd_data, patt(7));
    nextCycle();
    checkOutput("b2b_vld_end", 41'(rd_vld), 41'd0);

    // Read, then all three requests together: clear wins, read data still returns
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'h3A, 1'b0);
    checkOutput("pre_inv_rgnt", 41'(rd_gnt), 41'd1);
    nextCycle();
    applyStimulus(1'b1, 8'h20, 41'h0AB_CDEF_0123, {41{1'b1}}, 1'b1, 8'h3A, 1'b1);
    checkOutput("prio_gnt", 41'({wr_gnt, rd_gnt}), 41'd0);
    checkOutput("prio_cen", 41'(sram_cen), 41'd1);
    checkOutput("prio_vld", 41'(rd_vld), 41'd1);
    checkOutput("prio_rdata", rd_data, 41'h1_2345_6789A);
    nextCycle();
    applyStimulus(1'b1, 8'h20, 41'h0AB_CDEF_0123, {41{1'b1}}, 1'b1, 8'h3A, 1'b0);
    checkOutput("inv_vld0", 41'(rd_vld), 41'd0);
    for (int k = 0; k < 256; k++) begin
      checkOutput("inv_a", 41'(sram_a), 41'(k));
      checkOutput("inv_ctl", 41'({wr_gnt, rd_gnt, sram_gwen, inv_busy}), 41'b0001);
      nextCycle();
    end
    checkOutput("inv_done", 41'(inv_done), 41'd1);
    checkOutput("post_inv_wgnt", 41'({wr_gnt, rd_gnt}), 41'b10);
    checkOutput("post_inv_wa", 41'(sram_a), 41'h20);
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'h3A, 1'b0);
    checkOutput("post_inv_rgnt", 41'(rd_gnt), 41'd1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'h20, 1'b0);
    checkOutput("cleared_3a", rd_data, 41'd0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, 1'b0);
    checkOutput("post_inv_20", rd_data, 41'h0AB_CDEF_0123);
    nextCycle();

    // Reset during a read: no stale rd_vld
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b1, 8'h05, 1'b0);
    checkOutput("rstrd_gnt", 41'(rd_gnt), 41'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstrd_cen", 41'({sram_cen, rd_gnt, inv_busy}), 41'b101);
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, 1'b0);
    nextCycle();
    checkOutput("rstrd_vld", 41'(rd_vld), 41'd0);
    #1 rst_n = 1'b1;

    // Reset at sweep address 100, then restart from 0
    for (int k = 0; k <= 100; k++) nextCycle();
    checkOutput("mid_a100", 41'(sram_a), 41'd100);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cen", 41'({sram_cen, sram_gwen}), 41'b11);
    checkOutput("mid_rst_a", 41'(sram_a), 41'd0);
    #1 rst_n = 1'b1;
    nextCycle();
    checkOutput("restart_a0", 41'(sram_a), 41'd0);
    checkOutput("restart_cen", 41'(sram_cen), 41'd0);
    for (int k = 1; k < 256; k++) nextCycle();
    checkOutput("restart_a255", 41'(sram_a), 41'd255);
    checkOutput("restart_done_early", 41'(inv_done), 41'd0);
    nextCycle();
    checkOutput("restart_done", 41'(inv_done), 41'd1);
    nextCycle();
    checkOutput("restart_done_end", 41'(inv_done), 41'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
